axis_pkt_arbiter: RTL and testbench
===================================

# axis_pkt_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream sink, normally the input of the team's `axis_fifo`, between NUM_SRC AXI-Stream sources. It grants the sink to one source for one whole packet, delimited by TLAST. Beats from different sources never interleave. It sits between the producer blocks and the shared FIFO, and it neither buffers nor alters data.

## Interface
- DATA_WIDTH, 32, beat width in bits
- NUM_SRC, 4, number of sources (2..8)
- SRC_W, $clog2(NUM_SRC), localparam, grant index width
- clk  input  1  single clock, all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- S_TDATA  input  NUM_SRC*DATA_WIDTH  source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- S_TVALID  input  NUM_SRC  per-source valid
- S_TLAST  input  NUM_SRC  per-source end of packet
- S_TREADY  output  NUM_SRC  per-source ready
- M_TDATA  output  DATA_WIDTH  to shared sink
- M_TVALID  output  1  to shared sink
- M_TLAST  output  1  to shared sink
- M_TREADY  input  1  from shared sink
- GRANT  output  SRC_W  index of the current owner
- GRANT_VALID  output  1  high while a packet is owned (PASS state)

## Operation
- FSM has two states:
  - IDLE: no owner.
  - PASS: owner = GRANT.
- In IDLE, if any S_TVALID is high, the block picks a winner by round-robin from pointer rr_ptr.
  - The winner is the first i with S_TVALID[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_SRC.
  - At the next edge: GRANT <= winner, GRANT_VALID <= 1, state <= PASS.
- In PASS, the path is combinational:
  - M_TDATA/M_TLAST/M_TVALID = S_*[GRANT].
  - S_TREADY[GRANT] = M_TREADY.
  - All other S_TREADY = 0.
- A beat is accepted when M_TVALID && M_TREADY.
- An accepted beat with M_TLAST=1 ends ownership. At that edge:
  - state <= IDLE, GRANT_VALID <= 0.
  - rr_ptr <= GRANT+1, wrapping from NUM_SRC-1 to 0.
- The owner dropping S_TVALID mid-packet does not release the grant. The arbiter waits indefinitely.
- In IDLE:
  - M_TVALID = 0, M_TLAST = 0, M_TDATA = 0.
  - All S_TREADY = 0.
  - GRANT holds its last value.
- Simultaneous requests are resolved purely by rr_ptr. No source is starved: any requesting source is served within NUM_SRC-1 packets.
- Single-beat packets (TLAST on first beat) are legal.

## Timing
- Reset values:
  - state = IDLE, rr_ptr = 0, GRANT = 0, GRANT_VALID = 0.
  - M_TVALID = 0, M_TLAST = 0, M_TDATA = 0.
  - S_TREADY = 0.
- Arbitration latency:
  - Request seen in IDLE at cycle n: the first beat is presented on M at cycle n+1.
  - Data path inside PASS has zero latency.
- Between packets there is exactly one IDLE bubble cycle, even if the same or another source is already requesting.
- Burst throughput is one beat per cycle while M_TREADY=1.
- New requests in the TLAST-accept cycle are not considered until the following IDLE cycle.
- Reset asserted mid-packet forces IDLE immediately (asynchronous):
  - The packet is truncated and the sink does not see TLAST.
  - After release, arbitration restarts from rr_ptr = 0.
- Handshake rules:
  - M_TVALID must not depend on M_TREADY.
  - Combinational paths exist only S→M and M_TREADY→S_TREADY.

## Configuration
- AXIS_PKT_ARB_STATS_EN defined:
  - Adds output PKT_CNT, NUM_SRC*16 bits. Field i sits at [i*16 +: 16].
  - Field i increments on each accepted TLAST beat from source i and wraps from 0xFFFF to 0.
  - All fields reset to 0.
- Undefined: the port and counters are absent and the rest of the behaviour is identical.

## Test plan
- **Single source, 3-beat packet:** reset, then source 2 sends D=0xA1,0xA2,0xA3 (last on 0xA3) with M_TREADY=1.
  - GRANT=2 and GRANT_VALID=1 one cycle after the request.
  - M sees 0xA1..0xA3 on consecutive cycles.
  - IDLE is re-entered after the 0xA3 accept, with rr_ptr=3.
- **All four sources request at once**, each sending 2-beat packets:
  - Grant order is 0,1,2,3.
  - There is one bubble between packets and no interleaving.
  - Totals: 8 beats over 11 cycles after the first grant.
- **Backpressure:** M_TREADY toggles 1,0,1,0 during a 4-beat packet from source 1.
  - Each beat is held stable while M_TREADY=0.
  - S_TREADY[1] mirrors M_TREADY.
  - All other S_TREADY stay 0.
- **Owner stalls:** source 0 drops S_TVALID for 5 cycles mid-packet while source 3 requests.
  - GRANT stays 0.
  - Source 3 is granted only after source 0's TLAST.
- **Reset mid-packet:** reset_n pulled low after beat 2 of 4.
  - All outputs return to 0 in the same cycle.
  - After release, simultaneous requests from sources 1 and 0 are granted to 0 first.
- **With AXIS_PKT_ARB_STATS_EN:** source 1 sends 3 packets and source 3 sends 1.
  - PKT_CNT field 1 = 3, field 3 = 1, others 0.
  - Preloading with 65536 packets on source 0 wraps field 0 to 0.

Source files
------------

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream sink between NUM_SRC sources.
// Optional per-source packet counters: define AXIS_PKT_ARB_STATS_EN to add the PKT_CNT port.
module axis_pkt_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4,
    localparam int SRC_W     = $clog2(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] S_TDATA,
    input  logic [NUM_SRC-1:0]            S_TVALID,
    input  logic [NUM_SRC-1:0]            S_TLAST,
    output logic [NUM_SRC-1:0]            S_TREADY,
    output logic [DATA_WIDTH-1:0]         M_TDATA,
    output logic                          M_TVALID,
    output logic                          M_TLAST,
    input  logic                          M_TREADY,
    output logic [SRC_W-1:0]              GRANT,
    output logic                          GRANT_VALID
`ifdef AXIS_PKT_ARB_STATS_EN
    ,
    output logic [NUM_SRC*16-1:0]         PKT_CNT
`endif
);

    localparam int unsigned N_SRC_U = NUM_SRC;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SRC_W-1:0]   r_grant;
    logic [SRC_W-1:0]   w_grant_nxt;
    logic               r_grant_valid;
    logic               w_grant_valid_nxt;
    logic [SRC_W-1:0]   r_rr_ptr;
    logic [SRC_W-1:0]   w_rr_ptr_nxt;
    logic               w_last_accept;

    logic [NUM_SRC-1:0] w_req_rot;
    logic               w_found;
    logic [SRC_W-1:0]   w_offset;
    logic [SRC_W:0]     w_sum;
    logic [SRC_W-1:0]   w_winner;

    // Rotate requests so bit 0 is the source at rr_ptr; first set bit is the winner offset.
    assign w_req_rot = NUM_SRC'({S_TVALID, S_TVALID} >> r_rr_ptr);

    always_comb begin
        w_found  = 1'b0;
        w_offset = '0;
        for (int unsigned k = 0; k < N_SRC_U; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found  = 1'b1;
                w_offset = SRC_W'(k);
            end
        end
    end

    assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_offset};
    assign w_winner = (w_sum >= (SRC_W+1)'(NUM_SRC)) ? SRC_W'(w_sum - (SRC_W+1)'(NUM_SRC))
                                                      : SRC_W'(w_sum);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_grant_valid <= w_grant_valid_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_grant_valid_nxt = r_grant_valid;
        w_rr_ptr_nxt      = r_rr_ptr;
        w_last_accept     = 1'b0;
        M_TDATA           = '0;
        M_TVALID          = 1'b0;
        M_TLAST           = 1'b0;
        S_TREADY          = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt       = ST_PASS;
                    w_grant_nxt       = w_winner;
                    w_grant_valid_nxt = 1'b1;
                end
            end
            ST_PASS: begin
                for (int unsigned i = 0; i < N_SRC_U; i++) begin
                    if (r_grant == SRC_W'(i)) begin
                        M_TDATA     = S_TDATA[i*DATA_WIDTH +: DATA_WIDTH];
                        M_TVALID    = S_TVALID[i];
                        M_TLAST     = S_TLAST[i];
                        S_TREADY[i] = M_TREADY;
                    end
                end
                if (M_TVALID && M_TREADY && M_TLAST) begin
                    w_last_accept     = 1'b1;
                    w_state_nxt       = ST_IDLE;
                    w_grant_valid_nxt = 1'b0;
                    w_rr_ptr_nxt      = (r_grant == SRC_W'(NUM_SRC-1)) ? '0 : r_grant + 1'b1;
                end
            end
        endcase
    end

    assign GRANT       = r_grant;
    assign GRANT_VALID = r_grant_valid;

`ifdef AXIS_PKT_ARB_STATS_EN
    logic [NUM_SRC-1:0][15:0] r_pkt_cnt;

    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_cnt <= '0;
        end else if (w_last_accept) begin
            for (int unsigned i = 0; i < N_SRC_U; i++) begin
                if (r_grant == SRC_W'(i)) begin
                    r_pkt_cnt[i] <= r_pkt_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign PKT_CNT = r_pkt_cnt;
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: per-source packet buffers drive the inputs,
// a scoreboard of expected sink beats is checked on every accepted M beat.
module tb_axis_pkt_arbiter;

    localparam int DW = 32;
    localparam int NS = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NS*DW-1:0]  S_TDATA;
    logic [NS-1:0]     S_TVALID;
    logic [NS-1:0]     S_TLAST;
    logic [NS-1:0]     S_TREADY;
    logic [DW-1:0]     M_TDATA;
    logic              M_TVALID;
    logic              M_TLAST;
    logic              M_TREADY;
    logic [1:0]        GRANT;
    logic              GRANT_VALID;
`ifdef AXIS_PKT_ARB_STATS_EN
    logic [NS*16-1:0]  PKT_CNT;
`endif

    axis_pkt_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .S_TDATA    (S_TDATA),
        .S_TVALID   (S_TVALID),
        .S_TLAST    (S_TLAST),
        .S_TREADY   (S_TREADY),
        .M_TDATA    (M_TDATA),
        .M_TVALID   (M_TVALID),
        .M_TLAST    (M_TLAST),
        .M_TREADY   (M_TREADY),
        .GRANT      (GRANT),
        .GRANT_VALID(GRANT_VALID)
`ifdef AXIS_PKT_ARB_STATS_EN
        ,
        .PKT_CNT    (PKT_CNT)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    src;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] src_data [NS][16];
    logic          src_last [NS][16];
    int            src_len  [NS];
    int            src_pos  [NS];
    logic [NS-1:0] stall;
    logic          mready;
    int            n_checks = 0;
    int            n_pass   = 0;
    int            n_beats  = 0;
    int            cyc      = 0;
    int            first_cyc;
    int            last_cyc;

    task automatic reset_bench();
        for (int s = 0; s < NS; s++) begin
            src_len[s] = 0;
            src_pos[s] = 0;
        end
        stall     = '0;
        sb.delete();
        n_beats   = 0;
        first_cyc = -1;
        last_cyc  = -1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        S_TVALID = '0;
        S_TLAST  = '0;
        S_TDATA  = '0;
        mready   = 1'b1;
        M_TREADY = 1'b1;
        reset_bench();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic load_pkt(input int s, input logic [DW-1:0] base, input int n);
        for (int b = 0; b < n; b++) begin
            src_data[s][src_len[s]] = base + DW'(b);
            src_last[s][src_len[s]] = (b == n - 1);
            src_len[s]++;
        end
    endtask

    task automatic expect_beats(input int s, input logic [DW-1:0] base, input int n, input int total);
        exp_t e;
        for (int b = 0; b < n; b++) begin
            e.src  = 2'(s);
            e.data = base + DW'(b);
            e.last = (b == total - 1);
            sb.push_back(e);
        end
    endtask

    // One clock: drive at negedge, sample #1 later; sampled handshakes complete at the next posedge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < NS; i++) begin
            if (src_pos[i] < src_len[i] && !stall[i]) begin
                S_TVALID[i]         = 1'b1;
                S_TDATA[i*DW +: DW] = src_data[i][src_pos[i]];
                S_TLAST[i]          = src_last[i][src_pos[i]];
            end else begin
                S_TVALID[i]         = 1'b0;
                S_TDATA[i*DW +: DW] = '0;
                S_TLAST[i]          = 1'b0;
            end
        end
        M_TREADY = mready;
        #1;
        cyc++;
        for (int i = 0; i < NS; i++) begin
            if (S_TVALID[i] && S_TREADY[i]) src_pos[i]++;
        end
        if (M_TVALID && M_TREADY) begin
            n_beats++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got src=%0d data=%h last=%b, expected no beat",
                         GRANT, M_TDATA, M_TLAST);
            end else begin
                e = sb.pop_front();
                if (M_TDATA !== e.data || M_TLAST !== e.last || GRANT !== e.src)
                    $display("FAIL sb_beat: got src=%0d data=%h last=%b, expected src=%0d data=%h last=%b",
                             GRANT, M_TDATA, M_TLAST, e.src, e.data, e.last);
                else
                    n_pass++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        S_TVALID = '1;
        S_TLAST  = '1;
        S_TDATA  = {NS{32'hDEADBEEF}};
        M_TREADY = 1'b1;
        #3;
        n_checks++;
        if (M_TVALID !== 1'b0 || M_TLAST !== 1'b0 || M_TDATA !== '0 || S_TREADY !== '0)
            $display("FAIL reset_outputs: got mv=%b ml=%b md=%h sr=%b, expected all 0",
                     M_TVALID, M_TLAST, M_TDATA, S_TREADY);
        else n_pass++;
        n_checks++;
        if (GRANT !== 2'd0 || GRANT_VALID !== 1'b0)
            $display("FAIL reset_grant: got grant=%0d gv=%b, expected 0 0", GRANT, GRANT_VALID);
        else n_pass++;
`ifdef AXIS_PKT_ARB_STATS_EN
        n_checks++;
        if (PKT_CNT !== '0) $display("FAIL reset_pkt_cnt: got %h, expected 0", PKT_CNT);
        else n_pass++;
`endif
        do_reset();
        step();
        n_checks++;
        if (GRANT_VALID !== 1'b0 || M_TVALID !== 1'b0)
            $display("FAIL reset_idle_no_req: got gv=%b mv=%b, expected 0 0", GRANT_VALID, M_TVALID);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        load_pkt(2, 32'hA1, 3);
        expect_beats(2, 32'hA1, 3, 3);
        step();
        n_checks++;
        if (GRANT_VALID !== 1'b0 || M_TVALID !== 1'b0)
            $display("FAIL single_arb_cycle: got gv=%b mv=%b, expected 0 0", GRANT_VALID, M_TVALID);
        else n_pass++;
        step();
        n_checks++;
        if (GRANT !== 2'd2 || GRANT_VALID !== 1'b1 || M_TVALID !== 1'b1)
            $display("FAIL single_grant: got grant=%0d gv=%b mv=%b, expected 2 1 1", GRANT, GRANT_VALID, M_TVALID);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (n_beats !== 3 || sb.size() !== 0)
            $display("FAIL single_burst: got beats=%0d pending=%0d, expected 3 0", n_beats, sb.size());
        else n_pass++;
        step();
        n_checks++;
        if (GRANT_VALID !== 1'b0 || M_TVALID !== 1'b0 || GRANT !== 2'd2)
            $display("FAIL single_release: got gv=%b mv=%b grant=%0d, expected 0 0 2", GRANT_VALID, M_TVALID, GRANT);
        else n_pass++;
        // rr_ptr should now be 3, so source 3 beats source 0
        load_pkt(0, 32'hB0, 1);
        load_pkt(3, 32'hB3, 1);
        expect_beats(3, 32'hB3, 1, 1);
        expect_beats(0, 32'hB0, 1, 1);
        for (int k = 0; k < 10 && sb.size() > 0; k++) step();
        n_checks++;
        if (sb.size() !== 0) $display("FAIL single_rr_next: got pending=%0d, expected 0", sb.size());
        else n_pass++;
    endtask

    task automatic test_all_sources();
        do_reset();
        for (int s = 0; s < NS; s++) load_pkt(s, DW'(16 * (s + 1)), 2);
        for (int s = 0; s < NS; s++) expect_beats(s, DW'(16 * (s + 1)), 2, 2);
        for (int k = 0; k < 40 && sb.size() > 0; k++) step();
        n_checks++;
        if (sb.size() !== 0 || n_beats !== 8)
            $display("FAIL all_drain: got pending=%0d beats=%0d, expected 0 8", sb.size(), n_beats);
        else n_pass++;
        n_checks++;
        if (last_cyc - first_cyc + 1 !== 11)
            $display("FAIL all_span: got %0d cycles, expected 11", last_cyc - first_cyc + 1);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [NS-1:0] exp_sr;
        logic [DW-1:0] held_data;
        logic          held_valid;
        int            pre;
        do_reset();
        load_pkt(1, 32'hC0, 4);
        expect_beats(1, 32'hC0, 4, 4);
        held_valid = 1'b0;
        held_data  = '0;
        for (int k = 0; k < 30 && sb.size() > 0; k++) begin
            mready = (k % 2 == 1);
            pre    = n_beats;
            step();
            exp_sr = (k > 0 && pre < 4 && mready) ? 4'b0010 : 4'b0000;
            n_checks++;
            if (S_TREADY !== exp_sr)
                $display("FAIL bp_tready k=%0d: got %b, expected %b", k, S_TREADY, exp_sr);
            else n_pass++;
            if (held_valid) begin
                n_checks++;
                if (M_TVALID !== 1'b1 || M_TDATA !== held_data)
                    $display("FAIL bp_hold k=%0d: got mv=%b data=%h, expected 1 %h", k, M_TVALID, M_TDATA, held_data);
                else n_pass++;
            end
            held_valid = M_TVALID && !M_TREADY;
            held_data  = M_TDATA;
        end
        mready = 1'b1;
        n_checks++;
        if (sb.size() !== 0 || n_beats !== 4)
            $display("FAIL bp_drain: got pending=%0d beats=%0d, expected 0 4", sb.size(), n_beats);
        else n_pass++;
    endtask

    task automatic test_owner_stall();
        do_reset();
        load_pkt(0, 32'hD0, 4);
        load_pkt(3, 32'hE0, 2);
        expect_beats(0, 32'hD0, 4, 4);
        expect_beats(3, 32'hE0, 2, 2);
        for (int k = 0; k < 10 && n_beats < 2; k++) step();
        n_checks++;
        if (n_beats !== 2) $display("FAIL stall_pre: got beats=%0d, expected 2", n_beats);
        else n_pass++;
        stall[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            n_checks++;
            if (GRANT !== 2'd0 || GRANT_VALID !== 1'b1 || M_TVALID !== 1'b0 || S_TREADY[3] !== 1'b0)
                $display("FAIL stall_hold k=%0d: got grant=%0d gv=%b mv=%b sr3=%b, expected 0 1 0 0",
                         k, GRANT, GRANT_VALID, M_TVALID, S_TREADY[3]);
            else n_pass++;
        end
        stall[0] = 1'b0;
        for (int k = 0; k < 30 && sb.size() > 0; k++) step();
        n_checks++;
        if (sb.size() !== 0 || n_beats !== 6)
            $display("FAIL stall_drain: got pending=%0d beats=%0d, expected 0 6", sb.size(), n_beats);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        load_pkt(0, 32'hF0, 1);
        load_pkt(2, 32'h20, 4);
        expect_beats(0, 32'hF0, 1, 1);
        expect_beats(2, 32'h20, 2, 4);
        for (int k = 0; k < 20 && n_beats < 3; k++) step();
        n_checks++;
        if (n_beats !== 3) $display("FAIL rstmid_pre: got beats=%0d, expected 3", n_beats);
        else n_pass++;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (M_TVALID !== 1'b0 || M_TLAST !== 1'b0 || M_TDATA !== '0 || S_TREADY !== '0 ||
            GRANT !== 2'd0 || GRANT_VALID !== 1'b0)
            $display("FAIL rstmid_outputs: got mv=%b ml=%b md=%h sr=%b grant=%0d gv=%b, expected all 0",
                     M_TVALID, M_TLAST, M_TDATA, S_TREADY, GRANT, GRANT_VALID);
        else n_pass++;
        do_reset();
        load_pkt(1, 32'h41, 1);
        load_pkt(0, 32'h40, 1);
        expect_beats(0, 32'h40, 1, 1);
        expect_beats(1, 32'h41, 1, 1);
        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        n_checks++;
        if (sb.size() !== 0) $display("FAIL rstmid_restart: got pending=%0d, expected 0", sb.size());
        else n_pass++;
    endtask

`ifdef AXIS_PKT_ARB_STATS_EN
    task automatic test_stats();
        logic [NS*16-1:0] exp_cnt;
        do_reset();
        load_pkt(1, 32'h50, 2);
        load_pkt(1, 32'h60, 2);
        load_pkt(1, 32'h70, 2);
        load_pkt(3, 32'h90, 1);
        expect_beats(1, 32'h50, 2, 2);
        expect_beats(3, 32'h90, 1, 1);
        expect_beats(1, 32'h60, 2, 2);
        expect_beats(1, 32'h70, 2, 2);
        for (int k = 0; k < 40 && sb.size() > 0; k++) step();
        step();
        exp_cnt = {16'd1, 16'd0, 16'd3, 16'd0};
        n_checks++;
        if (sb.size() !== 0 || PKT_CNT !== exp_cnt)
            $display("FAIL stats_cnt: got pending=%0d cnt=%h, expected 0 %h", sb.size(), PKT_CNT, exp_cnt);
        else n_pass++;
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        S_TVALID = '0;
        S_TLAST  = '0;
        S_TDATA  = '0;
        M_TREADY = 1'b1;
        mready   = 1'b1;
        reset_bench();
        test_reset();
        test_single();
        test_all_sources();
        test_backpressure();
        test_owner_stall();
        test_reset_mid();
`ifdef AXIS_PKT_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
